// File: rtl/farm_vehicle_detector.sv
// Farm-road vehicle detector: synchronizes and debounces the inductive loop, counts
// waiting vehicles, and raises 'sensor' for traffic_control until they are all served.
module farm_vehicle_detector #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4,
    parameter int STUCK_CYCLES    = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             loop_raw,
    input  logic [2:0]       Farm_Light,
    output logic             sensor,
    output logic [CNT_W-1:0] vehicle_count,
    output logic             loop_fault
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ST_W = $clog2(STUCK_CYCLES + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0]  ST_LIMIT = ST_W'(STUCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESENT = 2'd1;
    localparam logic [1:0] ST_FAULT   = 2'd2;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [ST_W-1:0]  stuck_q, stuck_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sensor_q, sensor_d;

    logic toggle;
    logic arrive;
    logic depart;
    logic green;

    always_comb begin
        sync1_d = loop_raw;
        sync2_d = sync1_q;

        // Level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
        level_d  = level_q;
        db_cnt_d = '0;
        toggle   = 1'b0;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                toggle  = 1'b1;
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        arrive = toggle & ~level_q;
        depart = toggle & level_q;
        green  = (Farm_Light == 3'b001);

        stuck_d = '0;
        if (level_q) begin
            stuck_d = (stuck_q == ST_LIMIT) ? stuck_q : stuck_q + 1'b1;
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (arrive) state_d = ST_PRESENT;
            ST_PRESENT: begin
                if (depart) begin
                    state_d = ST_IDLE;
                end else if (stuck_d == ST_LIMIT) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT:   state_d = ST_FAULT;
            default:    state_d = ST_IDLE;
        endcase

        // A vehicle arriving on green drives straight through; one leaving on red is still queued.
        count_d = count_q;
        if (state_q != ST_FAULT) begin
            if (arrive && !green && count_q != CNT_MAX) begin
                count_d = count_q + 1'b1;
            end else if (depart && green && count_q != '0) begin
                count_d = count_q - 1'b1;
            end
        end

        sensor_d = (state_q == ST_FAULT) | level_q | (count_q != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            level_q  <= 1'b0;
            db_cnt_q <= '0;
            stuck_q  <= '0;
            state_q  <= ST_IDLE;
            count_q  <= '0;
            sensor_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
            stuck_q  <= stuck_d;
            state_q  <= state_d;
            count_q  <= count_d;
            sensor_q <= sensor_d;
        end
    end

    assign sensor        = sensor_q;
    assign vehicle_count = count_q;
    assign loop_fault    = (state_q == ST_FAULT);

endmodule

// File: tb/tb_farm_vehicle_detector.sv
// Self-checking bench for farm_vehicle_detector against a cycle-level behavioural model.
module tb_farm_vehicle_detector;

    localparam int DEB  = 4;
    localparam int CW   = 4;
    localparam int STK  = 50;
    localparam int CMAX = 15;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;

    logic          clk = 1'b0;
    logic          rst;
    logic          loop_raw;
    logic [2:0]    farm_light;
    logic          sensor;
    logic [CW-1:0] vehicle_count;
    logic          loop_fault;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_s1, m_s2, m_level, m_fault, m_sensor;
    int m_run, m_count, m_stuck;

    farm_vehicle_detector #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(CW),
        .STUCK_CYCLES(STK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .loop_raw(loop_raw),
        .Farm_Light(farm_light),
        .sensor(sensor),
        .vehicle_count(vehicle_count),
        .loop_fault(loop_fault)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_level = 0; m_fault = 0; m_sensor = 0;
        m_run = 0; m_count = 0; m_stuck = 0;
    endtask

    task automatic model_edge();
        bit sample, old_level, old_fault, toggled;
        int old_count;
        sample    = m_s2;
        m_s2      = m_s1;
        m_s1      = loop_raw;
        old_level = m_level;
        old_fault = m_fault;
        old_count = m_count;
        m_sensor  = old_fault || old_level || (old_count != 0);
        if (sample != m_level) m_run++;
        else m_run = 0;
        toggled = 0;
        if (m_run == DEB) begin
            toggled = 1;
            m_level = !m_level;
            m_run   = 0;
        end
        if (!old_fault) begin
            if (toggled && m_level && farm_light != GREEN && m_count < CMAX) m_count++;
            if (toggled && !m_level && farm_light == GREEN && m_count > 0) m_count--;
            m_stuck = old_level ? m_stuck + 1 : 0;
            if (old_level && !(toggled && !m_level) && m_stuck >= STK) m_fault = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1; farm_light = RED;
        for (int i = 0; i < 8; i++) begin
            loop_raw = i[0];
            tick();
            checks++;
            if (sensor !== 1'b0 || vehicle_count !== '0 || loop_fault !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d sensor=%b count=%0d fault=%b required all 0",
                         i, sensor, vehicle_count, loop_fault);
            end
        end
        loop_raw = 0;
        tick();
        rst = 0;
        loop_raw = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (sensor !== m_sensor || vehicle_count !== CW'(m_count) || loop_fault !== m_fault) begin
                errors++;
                $display("FAIL reset_enter cyc=%0d sensor=%b/%b count=%0d/%0d fault=%b/%b",
                         k, sensor, m_sensor, vehicle_count, m_count, loop_fault, m_fault);
            end
        end
        checks++;
        if (sensor !== 1'b1 || vehicle_count !== 4'd1) begin
            errors++;
            $display("FAIL reset_present sensor=%b count=%0d required 1 1", sensor, vehicle_count);
        end
        #3 rst = 1;
        model_reset();
        #1;
        checks++;
        if (sensor !== 1'b0 || vehicle_count !== '0 || loop_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_async sensor=%b count=%0d fault=%b required all 0",
                     sensor, vehicle_count, loop_fault);
        end
        loop_raw = 0;
        tick(); tick();
        rst = 0;
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic test_glitch();
        farm_light = RED;
        for (int k = 0; k < 15; k++) begin
            loop_raw = (k < 3);
            tick();
            checks++;
            if (sensor !== 1'b0 || vehicle_count !== '0 || sensor !== m_sensor ||
                vehicle_count !== CW'(m_count)) begin
                errors++;
                $display("FAIL glitch cyc=%0d sensor=%b count=%0d required 0 0", k, sensor, vehicle_count);
            end
        end
    endtask

    task automatic test_single_vehicle();
        farm_light = RED;
        loop_raw = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (sensor !== (k >= 6) || vehicle_count !== ((k >= 5) ? 4'd1 : 4'd0) ||
                sensor !== m_sensor || vehicle_count !== CW'(m_count)) begin
                errors++;
                $display("FAIL single_arrive edge=%0d sensor=%b required %b count=%0d required %0d",
                         k, sensor, (k >= 6), vehicle_count, (k >= 5) ? 1 : 0);
            end
        end
        loop_raw = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            checks++;
            if (sensor !== 1'b1 || vehicle_count !== 4'd1 || sensor !== m_sensor) begin
                errors++;
                $display("FAIL single_wait cyc=%0d sensor=%b count=%0d required 1 1", k, sensor, vehicle_count);
            end
        end
        farm_light = GREEN;
        loop_raw = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (sensor !== m_sensor || vehicle_count !== CW'(m_count)) begin
                errors++;
                $display("FAIL single_green cyc=%0d sensor=%b/%b count=%0d/%0d",
                         k, sensor, m_sensor, vehicle_count, m_count);
            end
        end
        loop_raw = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            checks++;
            if (sensor !== (k < 6) || vehicle_count !== ((k >= 5) ? 4'd0 : 4'd1) ||
                sensor !== m_sensor || vehicle_count !== CW'(m_count)) begin
                errors++;
                $display("FAIL single_depart edge=%0d sensor=%b required %b count=%0d required %0d",
                         k, sensor, (k < 6), vehicle_count, (k >= 5) ? 0 : 1);
            end
        end
    endtask

    task automatic test_saturation();
        farm_light = RED;
        for (int p = 0; p < 17; p++) begin
            for (int c = 0; c < 20; c++) begin
                loop_raw = (c < 10);
                tick();
                checks++;
                if (sensor !== m_sensor || vehicle_count !== CW'(m_count) || loop_fault !== m_fault) begin
                    errors++;
                    $display("FAIL sat_fill p=%0d c=%0d sensor=%b/%b count=%0d/%0d",
                             p, c, sensor, m_sensor, vehicle_count, m_count);
                end
            end
        end
        checks++;
        if (vehicle_count !== 4'd15) begin
            errors++;
            $display("FAIL sat_max count=%0d required 15", vehicle_count);
        end
        farm_light = GREEN;
        for (int p = 0; p < 16; p++) begin
            for (int c = 0; c < 20; c++) begin
                loop_raw = (c < 10);
                tick();
                checks++;
                if (sensor !== m_sensor || vehicle_count !== CW'(m_count) || loop_fault !== m_fault) begin
                    errors++;
                    $display("FAIL sat_drain p=%0d c=%0d sensor=%b/%b count=%0d/%0d",
                             p, c, sensor, m_sensor, vehicle_count, m_count);
                end
            end
        end
        checks++;
        if (vehicle_count !== 4'd0 || sensor !== 1'b0) begin
            errors++;
            $display("FAIL sat_empty count=%0d sensor=%b required 0 0", vehicle_count, sensor);
        end
    endtask

    task automatic test_pass_through();
        farm_light = GREEN;
        for (int c = 0; c < 40; c++) begin
            loop_raw = (c < 15);
            tick();
            checks++;
            if (vehicle_count !== 4'd0 || sensor !== m_sensor || loop_fault !== 1'b0) begin
                errors++;
                $display("FAIL pass cyc=%0d count=%0d required 0 sensor=%b required %b",
                         c, vehicle_count, sensor, m_sensor);
            end
        end
        checks++;
        if (sensor !== 1'b0) begin
            errors++;
            $display("FAIL pass_idle sensor=%b required 0", sensor);
        end
    endtask

    task automatic test_random();
        int  len;
        int  prev_count;
        bit  prev_fault;
        bit  v;
        logic [2:0] codes [4];
        codes[0] = GREEN; codes[1] = YELLOW; codes[2] = RED; codes[3] = 3'b000;
        v = 0;
        for (int seg = 0; seg < 150; seg++) begin
            v   = !v;
            len = $urandom_range(1, 30);
            for (int c = 0; c < len; c++) begin
                loop_raw = v;
                if ($urandom_range(0, 9) == 0) begin
                    if ($urandom_range(0, 3) == 0) farm_light = 3'($urandom);
                    else farm_light = codes[$urandom_range(0, 2)];
                end
                prev_count = m_count;
                prev_fault = m_fault;
                tick();
                checks++;
                if (sensor !== m_sensor || vehicle_count !== CW'(m_count) || loop_fault !== m_fault) begin
                    errors++;
                    $display("FAIL random seg=%0d c=%0d light=%b sensor=%b/%b count=%0d/%0d fault=%b/%b",
                             seg, c, farm_light, sensor, m_sensor, vehicle_count, m_count,
                             loop_fault, m_fault);
                end
                checks++;
                if ((prev_count != 0 || prev_fault) && sensor !== 1'b1) begin
                    errors++;
                    $display("FAIL random_hold seg=%0d sensor=%b required 1 (count was %0d)",
                             seg, sensor, prev_count);
                end
            end
        end
    endtask

    task automatic test_stuck();
        loop_raw = 0; farm_light = RED;
        rst = 1;
        tick(); tick();
        rst = 0;
        tick();
        loop_raw = 1;
        for (int k = 0; k < 70; k++) begin
            tick();
            checks++;
            if (loop_fault !== (k >= 55) || loop_fault !== m_fault || sensor !== m_sensor ||
                vehicle_count !== CW'(m_count)) begin
                errors++;
                $display("FAIL stuck_detect edge=%0d fault=%b required %b sensor=%b count=%0d",
                         k, loop_fault, (k >= 55), sensor, vehicle_count);
            end
        end
        loop_raw = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            checks++;
            if (loop_fault !== 1'b1 || sensor !== 1'b1 || vehicle_count !== 4'd1) begin
                errors++;
                $display("FAIL stuck_latched cyc=%0d fault=%b sensor=%b count=%0d required 1 1 1",
                         k, loop_fault, sensor, vehicle_count);
            end
        end
        #3 rst = 1;
        model_reset();
        #1;
        checks++;
        if (sensor !== 1'b0 || vehicle_count !== '0 || loop_fault !== 1'b0) begin
            errors++;
            $display("FAIL stuck_clear sensor=%b count=%0d fault=%b required all 0",
                     sensor, vehicle_count, loop_fault);
        end
        tick();
        rst = 0;
    endtask

    initial begin
        rst = 1; loop_raw = 0; farm_light = RED;
        model_reset();
        test_reset();
        test_glitch();
        test_single_vehicle();
        test_saturation();
        test_pass_through();
        test_random();
        test_stuck();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
